// File: rtl/audio_pwm_out.sv
// Audio output stage: buffers datapath samples in a small FIFO, then releases them at a fixed
// sample rate. Each released sample sets the duty cycle of a single-bit PWM output.
module audio_pwm_out #(
  parameter int DATA_W            = 11,
  parameter int DEPTH             = 16,
  parameter int FRAMES_PER_SAMPLE = 1,
  parameter int START_LEVEL       = 4
) (
  input  logic                         clkFPGA,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            sample_in,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  input  logic                         clear_flags,
  output logic                         pwm_out,
  output logic                         playing,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = (FRAMES_PER_SAMPLE > 1) ? $clog2(FRAMES_PER_SAMPLE) : 1;
  localparam logic [CW-1:0]     DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0]     START_C    = CW'(START_LEVEL);
  localparam logic [FW-1:0]     FRAME_LAST = FW'(FRAMES_PER_SAMPLE - 1);
  localparam logic [DATA_W-1:0] MIDSCALE   = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;
  state_t state, state_next;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] pwm_cnt, duty;
  logic [FW-1:0]     frame_cnt;
  logic              tick, full, empty, wr_en, pop;
  logic              overflow_set, underflow_set;

  // Handshake: sample_valid is a one-cycle offer with no retry. The sample is taken at the
  // edge where sample_valid && sample_ready; an offer while not ready is dropped and flagged.
  assign full         = (fifo_count == DEPTH_C);
  assign empty        = (fifo_count == '0);
  assign sample_ready = !full;
  assign wr_en        = sample_valid && !full;
  assign overflow_set = sample_valid && full;
  assign tick         = (pwm_cnt == '1) && (frame_cnt == FRAME_LAST);
  assign playing      = (state == PLAY);

  always_comb begin
    state_next    = state;
    pop           = 1'b0;
    underflow_set = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (fifo_count >= START_C) begin
            pop        = 1'b1;
            state_next = PLAY;
          end
        end
        PLAY: begin
          if (!empty) begin
            pop = 1'b1;
          end else begin
            underflow_set = 1'b1;
            state_next    = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clkFPGA) begin
    if (rst) begin
      state      <= IDLE;
      pwm_cnt    <= '0;
      frame_cnt  <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      duty       <= MIDSCALE;
      pwm_out    <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      state   <= state_next;
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == '1) begin
        frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
      end
      // Compare uses the pre-edge duty, so a new duty takes effect with the wrap to 0.
      pwm_out <= (pwm_cnt < duty);
      if (tick) begin
        duty <= pop ? mem[rd_ptr] : MIDSCALE;
      end
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      overflow  <= overflow_set  | (overflow  & ~clear_flags);
      underflow <= underflow_set | (underflow & ~clear_flags);
    end
  end

  always_ff @(posedge clkFPGA) begin
    if (!rst && wr_en) begin
      mem[wr_ptr] <= sample_in;
    end
  end

endmodule

// File: tb/tb_audio_pwm_out.sv
// Bench for audio_pwm_out: a queue-based reference model predicts per-cycle status and the
// high-clock count of every PWM frame; a monitor compares the DUT against those predictions.
module tb_audio_pwm_out;

  localparam int DATA_W      = 11;
  localparam int DEPTH       = 16;
  localparam int FPS         = 1;
  localparam int START_LEVEL = 4;
  localparam int CW          = $clog2(DEPTH + 1);
  localparam int SW          = CW + 4;
  localparam int FRAME_LEN   = 1 << DATA_W;
  localparam int TICK_LEN    = FRAME_LEN * FPS;
  localparam logic [DATA_W-1:0] MID = DATA_W'(FRAME_LEN / 2);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] sample_in = '0;
  logic              sample_valid = 1'b0;
  logic              clear_flags = 1'b0;
  logic              sample_ready, pwm_out, playing, overflow, underflow;
  logic [CW-1:0]     fifo_count;

  always #5 clk = ~clk;

  audio_pwm_out #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .FRAMES_PER_SAMPLE(FPS), .START_LEVEL(START_LEVEL)
  ) dut (
    .clkFPGA(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .clear_flags(clear_flags), .pwm_out(pwm_out),
    .playing(playing), .fifo_count(fifo_count), .overflow(overflow), .underflow(underflow)
  );

  // Reference model state
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_duty;
  bit                m_play, m_ovf, m_unf, m_tick, m_pop, m_ovf_set, m_unf_set, reset_seen;
  int                m_pre, n_edge;
  int                last_edge = -1;

  // Scoreboard queues: expected high count per frame, expected status per cycle
  logic [DATA_W-1:0] exp_q[$];
  logic [SW-1:0]     st_q[$];
  logic [SW-1:0]     exp_st, got_st;
  int                hi_acc;
  int                errors = 0;
  int                checks = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_play = 0; m_ovf = 0; m_unf = 0; m_duty = MID;
      n_edge = 0; last_edge = -1; reset_seen = 1;
      exp_q.delete();
      exp_q.push_back(MID);
    end else begin
      m_pre     = m_q.size();
      m_tick    = (n_edge % TICK_LEN) == TICK_LEN - 1;
      m_pop     = 0;
      m_ovf_set = 0;
      m_unf_set = 0;
      if (m_tick) begin
        m_pop = m_play ? (m_pre > 0) : (m_pre >= START_LEVEL);
        if (m_pop) begin
          m_duty = m_q.pop_front();
          m_play = 1;
        end else begin
          m_duty    = MID;
          m_unf_set = m_play;
          m_play    = 0;
        end
      end
      if (sample_valid) begin
        if (m_pre == DEPTH) m_ovf_set = 1;
        else m_q.push_back(sample_in);
      end
      m_ovf = m_ovf_set ? 1'b1 : (clear_flags ? 1'b0 : m_ovf);
      m_unf = m_unf_set ? 1'b1 : (clear_flags ? 1'b0 : m_unf);
      last_edge = n_edge;
      n_edge++;
      if (n_edge % FRAME_LEN == 0) exp_q.push_back(m_duty);
    end
    st_q.push_back({CW'(m_q.size()), (m_q.size() < DEPTH), m_play, m_ovf, m_unf});
  end

  always @(negedge clk) begin
    if (st_q.size() > 0) begin
      exp_st = st_q.pop_front();
      got_st = {fifo_count, sample_ready, playing, overflow, underflow};
      checks++;
      if (got_st !== exp_st) begin
        errors++;
        $display("FAIL status t=%0t: got {count,ready,playing,ovf,unf}=%h, expected %h",
                 $time, got_st, exp_st);
      end
    end
    if (last_edge < 0) begin
      hi_acc = 0;
      if (reset_seen) begin
        checks++;
        if (pwm_out !== 1'b0) begin
          errors++;
          $display("FAIL reset_pwm t=%0t: got pwm_out=%b, expected 0", $time, pwm_out);
        end
      end
    end else begin
      hi_acc += (pwm_out === 1'b1) ? 1 : 0;
      if (last_edge % FRAME_LEN == FRAME_LEN - 1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame_high t=%0t: got %0d high clocks, no expectation queued", $time, hi_acc);
        end else if (hi_acc != int'(exp_q[0])) begin
          errors++;
          $display("FAIL frame_high t=%0t: got %0d high clocks, expected %0d",
                   $time, hi_acc, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
        hi_acc = 0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset(input int n, input bit with_valid);
    rst          = 1'b1;
    sample_valid = with_valid;
    sample_in    = DATA_W'($urandom_range(0, FRAME_LEN - 1));
    clear_flags  = 1'b0;
    repeat (n) step();
    rst          = 1'b0;
    sample_valid = 1'b0;
  endtask

  task automatic write_sample(input logic [DATA_W-1:0] v);
    sample_valid = 1'b1;
    sample_in    = v;
    step();
    sample_valid = 1'b0;
  endtask

  // Returns at the negedge just before the edge whose tick phase is p.
  task automatic wait_phase(input int p);
    int guard;
    guard = 0;
    while (!(last_edge >= 0 && ((last_edge + 1) % TICK_LEN) == p) && guard < 3 * TICK_LEN) begin
      step();
      guard++;
    end
    if (guard >= 3 * TICK_LEN) begin
      checks++;
      errors++;
      $display("FAIL wait_phase: phase %0d not reached within %0d cycles", p, guard);
    end
  endtask

  task automatic wait_frames(input int k);
    repeat (k) begin
      wait_phase(TICK_LEN - 1);
      step();
    end
  endtask

  initial begin
    // Reset, prefill below start level, then top up, play out and underflow
    do_reset(2, 0);
    write_sample(100);
    write_sample(200);
    write_sample(300);
    wait_frames(1);
    step();
    write_sample(400);
    wait_frames(6);

    // Overflow, clear, drop-on-tick while full, write-on-tick while not full
    do_reset(1, 0);
    for (int i = 0; i < 17; i++) write_sample(DATA_W'($urandom_range(0, FRAME_LEN - 1)));
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    step();
    wait_phase(TICK_LEN - 1);
    write_sample(DATA_W'($urandom_range(0, FRAME_LEN - 1)));
    wait_phase(TICK_LEN - 1);
    write_sample(DATA_W'($urandom_range(0, FRAME_LEN - 1)));
    wait_frames(1);

    // Reset while playing with five buffered samples and a simultaneous write
    do_reset(1, 0);
    for (int i = 0; i < 6; i++) write_sample(DATA_W'($urandom_range(0, FRAME_LEN - 1)));
    wait_frames(1);
    wait_phase(700);
    do_reset(1, 1);
    wait_frames(1);

    // Extremes
    do_reset(1, 0);
    write_sample('0);
    write_sample(DATA_W'(FRAME_LEN - 1));
    write_sample('0);
    write_sample(DATA_W'(FRAME_LEN - 1));
    wait_frames(6);

    // Random traffic with sparse clears and a burst
    do_reset(1, 0);
    for (int c = 0; c < 8 * FRAME_LEN; c++) begin
      if (c >= 3 * FRAME_LEN + 100 && c < 3 * FRAME_LEN + 120) sample_valid = 1'b1;
      else sample_valid = ($urandom_range(0, 449) == 0);
      case ($urandom_range(0, 3))
        0:       sample_in = '0;
        1:       sample_in = DATA_W'(FRAME_LEN - 1);
        default: sample_in = DATA_W'($urandom_range(0, FRAME_LEN - 1));
      endcase
      clear_flags = ($urandom_range(0, 2999) == 0);
      step();
    end
    sample_valid = 1'b0;
    clear_flags  = 1'b0;
    wait_frames(1);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_pwm_out.md
# audio_pwm_out

Output stage directly downstream of `datapath`. It accepts the 11-bit processed audio samples the datapath produces, one per valid pulse, and buffers them in a small FIFO. It releases them at a fixed sample rate and renders each as the duty cycle of a single-bit PWM output that drives the board's audio pin through an RC filter. It also reports buffer level and sticky overflow/underflow status for debug LEDs.

## Interface
Parameters:
- `DATA_W`, 11: sample width, unsigned offset-binary; PWM frame length is 2^DATA_W clocks.
- `DEPTH`, 16: FIFO depth in samples (power of two).
- `FRAMES_PER_SAMPLE`, 1: PWM frames per output sample (≥1).
- `START_LEVEL`, 4: FIFO level required to leave IDLE (1..DEPTH).

Ports:
- `clkFPGA`, in, 1: the single clock domain.
- `rst`, in, 1: synchronous, active-high reset.
- `sample_in`, in, DATA_W: sample from the datapath.
- `sample_valid`, in, 1: one-cycle strobe; the sample is offered this cycle.
- `sample_ready`, out, 1: FIFO not full; combinational from `fifo_count`.
- `clear_flags`, in, 1: clears `overflow` and `underflow`.
- `pwm_out`, out, 1: registered PWM bit.
- `playing`, out, 1: high in the PLAY state.
- `fifo_count`, out, $clog2(DEPTH+1): current FIFO occupancy.
- `overflow`, out, 1: sticky; a sample was dropped because the FIFO was full.
- `underflow`, out, 1: sticky; the FIFO was empty at a sample tick while in PLAY.

## Operation
- **Reset.** `rst` high at a clock edge sets:
  - `pwm_cnt`, `frame_cnt`, `fifo_count`, read/write pointers = 0
  - `duty` = 2^(DATA_W-1) (midscale)
  - `pwm_out` = 0, `playing` = 0, `overflow` = 0, `underflow` = 0
  - `sample_in` and `sample_valid` are ignored while `rst` is high.
- **FIFO write.**
  - `sample_valid` && not full: the sample is stored and the count increments.
  - `sample_valid` && full: the sample is dropped and `overflow` is set.
  - Fullness is evaluated on the pre-edge count. A write and a pop in the same cycle while full means the write is dropped, `overflow` is set, and the count becomes DEPTH-1.
  - A write and a pop in the same cycle while not full leaves the count unchanged.
- **PWM counter.** `pwm_cnt` increments every clock and wraps from 2^DATA_W-1 to 0.
  - At each wrap, `frame_cnt` increments, wrapping at FRAMES_PER_SAMPLE-1.
  - The sample tick is the edge where `pwm_cnt` == 2^DATA_W-1 and `frame_cnt` == FRAMES_PER_SAMPLE-1.
- **State machine.** Two states, IDLE and PLAY; `playing` = (state == PLAY).
  - IDLE, tick, `fifo_count` ≥ START_LEVEL: pop the head into `duty` and go to PLAY.
  - IDLE, tick, otherwise: `duty` = midscale, stay in IDLE.
  - PLAY, tick, FIFO non-empty: pop the head into `duty`, stay in PLAY.
  - PLAY, tick, FIFO empty: `duty` = midscale, set `underflow`, go to IDLE.
- **PWM output.** `pwm_out` <= (`pwm_cnt` < `duty`), an unsigned compare at full DATA_W width, with no saturation.
  - `duty` = 0 gives a constant low output.
  - `duty` = 2^DATA_W-1 gives high for all but one clock per frame.
- **Flags.** `clear_flags` clears both flags. If a set event occurs in the same cycle, the set wins.

## Timing
- The FIFO write takes effect at the edge where `sample_valid` is sampled; `fifo_count` reflects it from the next cycle.
- `duty` updates on the tick edge, the same edge on which `pwm_cnt` wraps to 0, so each new frame starts with the new duty.
- `pwm_out` lags `pwm_cnt` by one cycle: the first clock of a frame outputs the previous frame's last compare.
- Sample-in to PWM latency: from the next tick (PLAY, FIFO previously empty) up to DEPTH ticks. One tick = FRAMES_PER_SAMPLE·2^DATA_W clocks.
- `sample_ready` deasserts in the same cycle `fifo_count` reaches DEPTH. The datapath must not rely on back-pressure; dropped samples are flagged only.
- `rst` mid-operation: full reset at the next edge, with buffered samples discarded.

## Test plan
1. **Reset.** Hold `rst` for 2 cycles, then no writes. Required: `pwm_out`=0, `playing`=0, `fifo_count`=0, `sample_ready`=1, flags=0. Thereafter `pwm_out` is high 1024 of every 2048 clocks (midscale, IDLE).
2. **Prefill.** Write 100, 200, 300 before the first tick. Required: `playing` stays 0 and `fifo_count`=3 after the tick. Write 400. Required: at the next tick `playing`=1, `fifo_count`=3, and the following frame has `pwm_out` high for exactly 100 clocks.
3. **Overflow.** Write 17 samples back-to-back with no tick. Required: `fifo_count`=16, `sample_ready`=0, `overflow`=1, 17th sample absent. Pulse `clear_flags`. Required: `overflow`=0.
4. **Underflow.** Prefill 4 samples, then stop writing. Required: 4 frames play the samples; at the 5th tick `underflow`=1, `playing`=0, and the next frame is 1024 high.
5. **Extremes.** Play samples 0 and 2047. Required: frame 1 has `pwm_out` low for all 2048 clocks; frame 2 is high for 2047 clocks, low for 1.
6. **Reset mid-play.** Assert `rst` for 1 cycle in PLAY with `fifo_count`=5. Required: next cycle `fifo_count`=0, `playing`=0, `pwm_out`=0, flags=0, counters=0, and a simultaneous `sample_valid` is ignored.
